// File: rtl/uart_rx_scheduler_if.sv
// uart_rx_scheduler_if
// Bundles the receive-side frame signals and the shared FIFO read port of
// uart_rx_scheduler.
//   rx_transaction_en  receiver is in the middle of a frame
//   rx_data / rx_wr    completed frame and its one-cycle strobe
//   rx_valid           parity check result, sampled with rx_wr
//   rd_req_0/1         read requests from the two pipes
//   rd_gnt_0/1         one-cycle grant, rd_data/rd_err valid with it
// Modports: slave = the scheduler, master = receiver plus pipes.
interface uart_rx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_transaction_en;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_wr;
  logic                  rx_valid;
  logic                  rd_req_0;
  logic                  rd_req_1;
  logic                  rd_gnt_0;
  logic                  rd_gnt_1;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  modport slave (
    input  rx_transaction_en, rx_data, rx_wr, rx_valid, rd_req_0, rd_req_1,
    output rd_gnt_0, rd_gnt_1, rd_data, rd_err
  );

  modport master (
    output rx_transaction_en, rx_data, rx_wr, rx_valid, rd_req_0, rd_req_1,
    input  rd_gnt_0, rd_gnt_1, rd_data, rd_err
  );
endinterface

// File: rtl/uart_rx_scheduler.sv
// uart_rx_scheduler
// Sits between the UART receive controller and the two instruction pipes.
//  - Holds the receiver frame configuration. Software writes land in a shadow
//    copy and are applied only while no frame is in progress.
//  - Buffers received frames as {err, data} in a FIFO_DEPTH-entry FIFO.
//  - Grants FIFO reads to two requesters round-robin.
//  - Keeps a sticky overrun flag and a saturating parity error count.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_wr, cfg_*_in            software config write strobe and values
//   cfg_pending                 shadow written but not applied yet
//   *_option                    active config driven to the receiver
//   bus (slave)                 receive frame and FIFO read signals
//   fifo_empty, fifo_full       FIFO status
//   overrun, parity_err_cnt     statistics, cleared by stat_clr
// Build option: RX_ERR_DROP_EN - frames failing parity are counted but not
// queued, and rd_err is tied low.
module uart_rx_scheduler #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 8,
  parameter int DATA_WIDTH_OPTION_W = 2,
  parameter int PARITY_OPTION_W     = 2,
  parameter int STOP_BIT_OPTION_W   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_wr,
  input  logic [DATA_WIDTH_OPTION_W-1:0] cfg_data_width_in,
  input  logic [PARITY_OPTION_W-1:0]     cfg_parity_in,
  input  logic [STOP_BIT_OPTION_W-1:0]   cfg_stop_bit_in,
  output logic                           cfg_pending,
  output logic [DATA_WIDTH_OPTION_W-1:0] data_width_option,
  output logic [PARITY_OPTION_W-1:0]     parity_option,
  output logic [STOP_BIT_OPTION_W-1:0]   stop_bit_option,
  uart_rx_scheduler_if.slave             bus,
  output logic                           fifo_empty,
  output logic                           fifo_full,
  output logic                           overrun,
  output logic [7:0]                     parity_err_cnt,
  input  logic                           stat_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH_OPTION_W-1:0] DW_RESET = {DATA_WIDTH_OPTION_W{1'b1}};

  // ---------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------
  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

  cfg_state_t                     cfg_state_reg;
  logic                           cfg_pending_reg;
  logic [DATA_WIDTH_OPTION_W-1:0] sh_dw_reg, act_dw_reg;
  logic [PARITY_OPTION_W-1:0]     sh_par_reg, act_par_reg;
  logic [STOP_BIT_OPTION_W-1:0]   sh_stop_reg, act_stop_reg;

  // Applying is safe only when the receiver is between frames and is not
  // handing over a completed frame in this cycle.
  logic apply_ok;
  assign apply_ok = !bus.rx_transaction_en && !bus.rx_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_state_reg   <= CFG_IDLE;
      cfg_pending_reg <= 1'b0;
      sh_dw_reg       <= DW_RESET;
      sh_par_reg      <= '0;
      sh_stop_reg     <= '0;
      act_dw_reg      <= DW_RESET;
      act_par_reg     <= '0;
      act_stop_reg    <= '0;
    end else begin
      // A write always refreshes the shadow; in CFG_PEND it also defers any
      // apply that would have happened this cycle.
      if (cfg_wr) begin
        sh_dw_reg   <= cfg_data_width_in;
        sh_par_reg  <= cfg_parity_in;
        sh_stop_reg <= cfg_stop_bit_in;
      end
      case (cfg_state_reg)
        CFG_IDLE: begin
          if (cfg_wr) begin
            cfg_state_reg   <= CFG_PEND;
            cfg_pending_reg <= 1'b1;
          end
        end
        CFG_PEND: begin
          if (!cfg_wr && apply_ok) begin
            act_dw_reg      <= sh_dw_reg;
            act_par_reg     <= sh_par_reg;
            act_stop_reg    <= sh_stop_reg;
            cfg_state_reg   <= CFG_IDLE;
            cfg_pending_reg <= 1'b0;
          end
        end
        default: begin
          cfg_state_reg   <= CFG_IDLE;
          cfg_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_pending       = cfg_pending_reg;
  assign data_width_option = act_dw_reg;
  assign parity_option     = act_par_reg;
  assign stop_bit_option   = act_stop_reg;

  // ---------------------------------------------------------------------
  // FIFO pointers and status (extra MSB separates full from empty)
  // ---------------------------------------------------------------------
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        empty_w, full_w;

  assign empty_w = (wr_ptr_reg == rd_ptr_reg);
  assign full_w  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // ---------------------------------------------------------------------
  // Arbiter: last_gnt1_reg=1 means requester 1 won most recently
  // ---------------------------------------------------------------------
  logic last_gnt1_reg;
  logic pick0, pop;

  assign pop   = !empty_w && (bus.rd_req_0 || bus.rd_req_1);
  assign pick0 = bus.rd_req_0 && (!bus.rd_req_1 || last_gnt1_reg);

  // ---------------------------------------------------------------------
  // Push decision
  // ---------------------------------------------------------------------
  logic push_cand, push, drop;

`ifdef RX_ERR_DROP_EN
  assign push_cand = bus.rx_wr && bus.rx_valid;
`else
  assign push_cand = bus.rx_wr;
`endif
  // A pop at the same edge frees the slot being written when full.
  assign push = push_cand && (!full_w || pop);
  assign drop = push_cand && full_w && !pop;

  // ---------------------------------------------------------------------
  // Storage (no reset; read data is registered on pop)
  // ---------------------------------------------------------------------
`ifdef RX_ERR_DROP_EN
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= bus.rx_data;
    end
  end
`else
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {~bus.rx_valid, bus.rx_data};
    end
  end
`endif

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_err_reg;
  logic                  gnt0_reg, gnt1_reg;
  logic                  overrun_reg;
  logic [7:0]            perr_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      last_gnt1_reg <= 1'b1;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      rd_data_reg   <= '0;
      rd_err_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      perr_cnt_reg  <= '0;
    end else begin
      gnt0_reg <= pop && pick0;
      gnt1_reg <= pop && !pick0;
      if (pop) begin
        last_gnt1_reg <= !pick0;
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
`ifdef RX_ERR_DROP_EN
        rd_data_reg   <= mem[rd_ptr_reg[AW-1:0]];
        rd_err_reg    <= 1'b0;
`else
        {rd_err_reg, rd_data_reg} <= mem[rd_ptr_reg[AW-1:0]];
`endif
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      // New events take priority over a coincident clear.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (stat_clr) begin
        overrun_reg <= 1'b0;
      end
      if (bus.rx_wr && !bus.rx_valid) begin
        if (stat_clr) begin
          perr_cnt_reg <= 8'd1;
        end else if (perr_cnt_reg != 8'hFF) begin
          perr_cnt_reg <= perr_cnt_reg + 8'd1;
        end
      end else if (stat_clr) begin
        perr_cnt_reg <= '0;
      end
    end
  end

  assign bus.rd_gnt_0  = gnt0_reg;
  assign bus.rd_gnt_1  = gnt1_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_err    = rd_err_reg;
  assign fifo_empty    = empty_w;
  assign fifo_full     = full_w;
  assign overrun       = overrun_reg;
  assign parity_err_cnt = perr_cnt_reg;
endmodule

// File: tb/tb_uart_rx_scheduler.sv
// tb_uart_rx_scheduler
// Directed table, hand-written corner sequences and a randomized phase
// checked against a queue-based reference model of uart_rx_scheduler.
module tb_uart_rx_scheduler;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_dw_in, cfg_par_in;
  logic       cfg_stop_in;
  logic       cfg_pending;
  logic [1:0] dw_opt, par_opt;
  logic       stop_opt;
  logic       fifo_empty, fifo_full, overrun;
  logic [7:0] perr_cnt;
  logic       stat_clr;

  uart_rx_scheduler_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_scheduler #(
    .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .DATA_WIDTH_OPTION_W(2),
    .PARITY_OPTION_W(2), .STOP_BIT_OPTION_W(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr),
    .cfg_data_width_in(cfg_dw_in), .cfg_parity_in(cfg_par_in),
    .cfg_stop_bit_in(cfg_stop_in), .cfg_pending(cfg_pending),
    .data_width_option(dw_opt), .parity_option(par_opt),
    .stop_bit_option(stop_opt), .bus(bus.slave),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overrun(overrun),
    .parity_err_cnt(perr_cnt), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] m_q[$];
  bit         m_last1, m_over, m_pend, m_gnt0, m_gnt1, m_rd_err;
  logic [7:0] m_rd_data;
  int         m_cnt;
  logic [1:0] m_sh_dw, m_sh_par, m_act_dw, m_act_par;
  bit         m_sh_stop, m_act_stop;
  bit         mchk = 0;

  task automatic model_reset();
    m_q.delete();
    m_last1 = 1; m_over = 0; m_pend = 0; m_gnt0 = 0; m_gnt1 = 0;
    m_rd_err = 0; m_rd_data = 0; m_cnt = 0;
    m_sh_dw = 2'b11; m_sh_par = 0; m_sh_stop = 0;
    m_act_dw = 2'b11; m_act_par = 0; m_act_stop = 0;
  endtask

  // Applies the behaviour of one clock edge given the inputs held before it.
  task automatic model_edge();
    int  sz;
    bit  was_full, do_pop, g0, cand;
    logic [8:0] e;
    if (rst) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    was_full = (sz == DEPTH);
    do_pop = (sz > 0) && (bus.rd_req_0 || bus.rd_req_1);
    m_gnt0 = 0; m_gnt1 = 0;
    if (do_pop) begin
      if (bus.rd_req_0 && bus.rd_req_1) g0 = m_last1;
      else g0 = bus.rd_req_0;
      m_gnt0 = g0; m_gnt1 = !g0; m_last1 = !g0;
      e = m_q.pop_front();
      m_rd_data = e[7:0];
      m_rd_err  = e[8];
    end
`ifdef RX_ERR_DROP_EN
    cand = bus.rx_wr && bus.rx_valid;
`else
    cand = bus.rx_wr;
`endif
    if (cand && (!was_full || do_pop)) m_q.push_back({~bus.rx_valid, bus.rx_data});
    if (cand && was_full && !do_pop) m_over = 1;
    else if (stat_clr) m_over = 0;
    if (bus.rx_wr && !bus.rx_valid) m_cnt = stat_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    else if (stat_clr) m_cnt = 0;
    if (m_pend) begin
      if (cfg_wr) begin
        m_sh_dw = cfg_dw_in; m_sh_par = cfg_par_in; m_sh_stop = cfg_stop_in;
      end else if (!bus.rx_transaction_en && !bus.rx_wr) begin
        m_act_dw = m_sh_dw; m_act_par = m_sh_par; m_act_stop = m_sh_stop;
        m_pend = 0;
      end
    end else if (cfg_wr) begin
      m_sh_dw = cfg_dw_in; m_sh_par = cfg_par_in; m_sh_stop = cfg_stop_in;
      m_pend = 1;
    end
  endtask

  task automatic model_compare();
    chk("m_empty", fifo_empty, m_q.size() == 0);
    chk("m_full", fifo_full, m_q.size() == DEPTH);
    chk("m_overrun", overrun, m_over);
    chk("m_perr_cnt", perr_cnt, m_cnt);
    chk("m_cfg_pending", cfg_pending, m_pend);
    chk("m_dw_opt", dw_opt, m_act_dw);
    chk("m_par_opt", par_opt, m_act_par);
    chk("m_stop_opt", stop_opt, m_act_stop);
    chk("m_gnt0", bus.rd_gnt_0, m_gnt0);
    chk("m_gnt1", bus.rd_gnt_1, m_gnt1);
    chk("m_rd_data", bus.rd_data, m_rd_data);
`ifdef RX_ERR_DROP_EN
    chk("m_rd_err", bus.rd_err, 0);
`else
    chk("m_rd_err", bus.rd_err, m_rd_err);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (mchk) model_compare();
  endtask

  task automatic idle_inputs();
    cfg_wr = 0; cfg_dw_in = 2'b11; cfg_par_in = 0; cfg_stop_in = 0; stat_clr = 0;
    bus.rx_transaction_en = 0; bus.rx_data = 0; bus.rx_wr = 0; bus.rx_valid = 1;
    bus.rd_req_0 = 0; bus.rd_req_1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic push_frame(logic [7:0] d);
    bus.rx_wr = 1; bus.rx_valid = 1; bus.rx_data = d;
    step();
    bus.rx_wr = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit cfg_wr; logic [1:0] par; bit trans; bit rx_wr; bit rx_valid;
    logic [7:0] data; bit req0; bit req1; bit sclr;
    bit e_pend; logic [1:0] e_par; bit e_empty; bit e_g0; bit e_g1;
    logic [7:0] e_rd; bit e_err; int e_cnt;
  } vec_t;

  vec_t vt[11];

`ifdef RX_ERR_DROP_EN
  localparam bit DROP = 1;
`else
  localparam bit DROP = 0;
`endif

  initial begin
    vt[0]  = '{1,2'd1,1,0,1,8'h00,0,0,0,  1,2'd0,1,0,0,8'h00,0,0};
    vt[1]  = '{0,2'd0,1,0,1,8'h00,0,0,0,  1,2'd0,1,0,0,8'h00,0,0};
    vt[2]  = '{0,2'd0,0,0,1,8'h00,0,0,0,  0,2'd1,1,0,0,8'h00,0,0};
    vt[3]  = '{0,2'd0,0,1,1,8'h11,0,0,0,  0,2'd1,0,0,0,8'h00,0,0};
    vt[4]  = '{0,2'd0,0,1,0,8'h33,1,0,0,  0,2'd1,DROP,1,0,8'h11,0,1};
    vt[5]  = '{0,2'd0,0,0,1,8'h00,0,1,0,  0,2'd1,1,0,!DROP,DROP?8'h11:8'h33,!DROP,1};
    vt[6]  = '{0,2'd0,0,1,0,8'h44,0,0,1,  0,2'd1,DROP,0,0,DROP?8'h11:8'h33,!DROP,1};
    vt[7]  = '{0,2'd0,0,0,1,8'h00,0,0,1,  0,2'd1,DROP,0,0,DROP?8'h11:8'h33,!DROP,0};
    vt[8]  = '{1,2'd2,0,0,1,8'h00,0,0,0,  1,2'd1,DROP,0,0,DROP?8'h11:8'h33,!DROP,0};
    vt[9]  = '{1,2'd3,0,0,1,8'h00,0,0,0,  1,2'd1,DROP,0,0,DROP?8'h11:8'h33,!DROP,0};
    vt[10] = '{0,2'd0,0,0,1,8'h00,0,0,0,  0,2'd3,DROP,0,0,DROP?8'h11:8'h33,!DROP,0};

    // ---- reset state ----
    do_reset();
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_gnt0", bus.rd_gnt_0, 0);
    chk("rst_gnt1", bus.rd_gnt_1, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt", perr_cnt, 0);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_dw", dw_opt, 2'b11);
    chk("rst_par", par_opt, 0);
    chk("rst_stop", stop_opt, 0);
    $display("reset: state checked");

    // ---- table ----
    for (int i = 0; i < 11; i++) begin
      cfg_wr = vt[i].cfg_wr; cfg_par_in = vt[i].par; cfg_dw_in = 2'b11;
      bus.rx_transaction_en = vt[i].trans; bus.rx_wr = vt[i].rx_wr;
      bus.rx_valid = vt[i].rx_valid; bus.rx_data = vt[i].data;
      bus.rd_req_0 = vt[i].req0; bus.rd_req_1 = vt[i].req1; stat_clr = vt[i].sclr;
      step();
      $display("vec %0d: pend=%0d par=%0d empty=%0d g0=%0d g1=%0d rd=%02h err=%0d cnt=%0d",
               i, cfg_pending, par_opt, fifo_empty, bus.rd_gnt_0, bus.rd_gnt_1,
               bus.rd_data, bus.rd_err, perr_cnt);
      chk($sformatf("vec%0d_pend", i), cfg_pending, vt[i].e_pend);
      chk($sformatf("vec%0d_par", i), par_opt, vt[i].e_par);
      chk($sformatf("vec%0d_empty", i), fifo_empty, vt[i].e_empty);
      chk($sformatf("vec%0d_g0", i), bus.rd_gnt_0, vt[i].e_g0);
      chk($sformatf("vec%0d_g1", i), bus.rd_gnt_1, vt[i].e_g1);
      chk($sformatf("vec%0d_rd", i), bus.rd_data, vt[i].e_rd);
      chk($sformatf("vec%0d_err", i), bus.rd_err, vt[i].e_err);
      chk($sformatf("vec%0d_cnt", i), perr_cnt, vt[i].e_cnt);
    end
    idle_inputs();

    // ---- overrun: 9 pushes into 8 entries, then drain ----
    do_reset();
    for (int i = 1; i <= 9; i++) push_frame(8'(i));
    chk("ovr_full", fifo_full, 1);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      bus.rd_req_0 = 1;
      step();
      bus.rd_req_0 = 0;
      $display("overrun drain: gnt0=%0d data=%02h", bus.rd_gnt_0, bus.rd_data);
      chk("ovr_gnt", bus.rd_gnt_0, 1);
      chk("ovr_data", bus.rd_data, i);
      step();
    end
    chk("ovr_empty", fifo_empty, 1);
    chk("ovr_sticky", overrun, 1);

    // ---- round robin with both requests held ----
    do_reset();
    push_frame(8'hA1); push_frame(8'hB2); push_frame(8'hC3); push_frame(8'hD4);
    bus.rd_req_0 = 1; bus.rd_req_1 = 1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_d;
      step();
      case (i)
        0: exp_d = 8'hA1;
        1: exp_d = 8'hB2;
        2: exp_d = 8'hC3;
        default: exp_d = 8'hD4;
      endcase
      $display("rr %0d: gnt0=%0d gnt1=%0d data=%02h", i, bus.rd_gnt_0, bus.rd_gnt_1, bus.rd_data);
      chk("rr_gnt0", bus.rd_gnt_0, (i % 2) == 0);
      chk("rr_gnt1", bus.rd_gnt_1, (i % 2) == 1);
      chk("rr_data", bus.rd_data, exp_d);
    end
    step();
    chk("rr_no_pop_empty_g0", bus.rd_gnt_0, 0);
    chk("rr_no_pop_empty_g1", bus.rd_gnt_1, 0);
    idle_inputs();

    // ---- full FIFO with simultaneous push and pop ----
    do_reset();
    for (int i = 0; i < 8; i++) push_frame(8'h10 + 8'(i));
    chk("fpp_full_before", fifo_full, 1);
    bus.rx_wr = 1; bus.rx_valid = 1; bus.rx_data = 8'h5A; bus.rd_req_0 = 1;
    step();
    bus.rx_wr = 0; bus.rd_req_0 = 0;
    $display("full push+pop: gnt0=%0d data=%02h full=%0d overrun=%0d",
             bus.rd_gnt_0, bus.rd_data, fifo_full, overrun);
    chk("fpp_data", bus.rd_data, 8'h10);
    chk("fpp_overrun", overrun, 0);
    chk("fpp_full", fifo_full, 1);
    for (int i = 0; i < 8; i++) begin
      bus.rd_req_1 = 1;
      step();
      bus.rd_req_1 = 0;
      step();
    end
    chk("fpp_last", bus.rd_data, 8'h5A);
    chk("fpp_empty", fifo_empty, 1);

    // ---- reset mid-stream ----
    do_reset();
    push_frame(8'h01); push_frame(8'h02); push_frame(8'h03);
    bus.rx_transaction_en = 1; cfg_wr = 1; cfg_par_in = 2'd2; cfg_dw_in = 2'd0; cfg_stop_in = 1;
    step();
    cfg_wr = 0;
    chk("rms_pend_before", cfg_pending, 1);
    bus.rd_req_0 = 1;
    rst = 1;
    step();
    rst = 0;
    $display("reset mid-stream: empty=%0d pend=%0d gnt0=%0d", fifo_empty, cfg_pending, bus.rd_gnt_0);
    chk("rms_empty", fifo_empty, 1);
    chk("rms_pend", cfg_pending, 0);
    chk("rms_dw", dw_opt, 2'b11);
    chk("rms_par", par_opt, 0);
    chk("rms_stop", stop_opt, 0);
    chk("rms_gnt0", bus.rd_gnt_0, 0);
    bus.rx_transaction_en = 0;
    step();
    chk("rms_gnt0_after", bus.rd_gnt_0, 0);
    chk("rms_pend_after", cfg_pending, 0);
    idle_inputs();

    // ---- randomized phase against the model ----
    do_reset();
    mchk = 1;
    for (int c = 0; c < 800; c++) begin
      int wr_pct, rq_pct;
      wr_pct = (c < 400) ? 60 : 20;
      rq_pct = (c < 400) ? 15 : 60;
      cfg_wr      = ($urandom_range(0, 15) == 0);
      cfg_dw_in   = 2'($urandom);
      cfg_par_in  = 2'($urandom);
      cfg_stop_in = 1'($urandom);
      stat_clr    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 7) == 0) bus.rx_transaction_en = ~bus.rx_transaction_en;
      bus.rx_wr    = ($urandom_range(0, 99) < wr_pct);
      bus.rx_valid = ($urandom_range(0, 3) != 0);
      bus.rx_data  = 8'($urandom);
      // Requesters hold until granted and drop in the grant cycle.
      if (m_gnt0) bus.rd_req_0 = 0;
      else if (!bus.rd_req_0) bus.rd_req_0 = ($urandom_range(0, 99) < rq_pct);
      if (m_gnt1) bus.rd_req_1 = 0;
      else if (!bus.rd_req_1) bus.rd_req_1 = ($urandom_range(0, 99) < rq_pct);
      step();
      if (m_gnt0 || m_gnt1)
        $display("rand pop c=%0d: gnt=%0d data=%02h err=%0d", c, m_gnt1, bus.rd_data, bus.rd_err);
    end
    mchk = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
